// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 master shift engine.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_TRAIL = 2'd3
    } spi_state_e;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_CLK_DIV = 4;

    // Wide enough to hold the value DATA_W itself, not just DATA_W-1.
    function automatic int bit_cnt_w(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/spi_master_engine_if.sv
// Host-side request/response signals plus the SPI pins of the master engine.
interface spi_master_engine_if
    import spi_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    // Handshake: start is a one-cycle request, accepted only while busy=0.
    // busy stays high from the accept edge until the edge where spi_done
    // rises; spi_done and rx_data then hold until the next accepted start.
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              busy;
    logic [DATA_W-1:0] rx_data;
    logic              spi_done;
    logic              SCLK;
    logic              MOSI;
    logic              MISO;
    logic              SS_n;
    spi_state_e        state_dbg;

    modport master (
        input  start, tx_data, MISO,
        output busy, rx_data, spi_done, SCLK, MOSI, SS_n, state_dbg
    );

    modport slave (
        output start, tx_data, MISO,
        input  busy, rx_data, spi_done, SCLK, MOSI, SS_n, state_dbg
    );

endinterface

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: one-cycle tick every CLK_DIV enabled cycles.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == CW'(CLK_DIV - 1));
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_engine.sv
// SPI mode-0 master: shifts a latched word out on MOSI, MSB first, while
// collecting MISO into rx_data; spi_done is a sticky completion flag.
module spi_master_engine
    import spi_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic                PCLK,
    input  logic                PRESET,
    spi_master_engine_if.master bus
);
    localparam int BCW = bit_cnt_w(DATA_W);

    spi_state_e        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic              miso_s_q, miso_s_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              ss_n_q, ss_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic tick;
    logic accept;
    logic last_bit_done;

    assign accept        = (state_q == ST_IDLE) && bus.start;
    assign last_bit_done = !sclk_q && (bit_cnt_q == BCW'(DATA_W));

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .en     (state_q != ST_IDLE),
        .clr    (accept),
        .tick   (tick)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_LEAD;
            ST_LEAD:  if (tick) state_d = ST_SHIFT;
            // One full SCLK-low half-period after the last falling edge.
            ST_SHIFT: if (tick && last_bit_done) state_d = ST_TRAIL;
            ST_TRAIL: if (tick) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shreg_d   = shreg_q;
        rx_d      = rx_q;
        bit_cnt_d = bit_cnt_q;
        miso_s_d  = miso_s_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ss_n_d    = ss_n_q;
        busy_d    = busy_q;
        done_d    = done_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    shreg_d   = bus.tx_data;
                    bit_cnt_d = '0;
                    ss_n_d    = 1'b0;
                    mosi_d    = bus.tx_data[DATA_W-1];
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                end
            end
            ST_LEAD: begin
                if (tick) begin
                    sclk_d   = 1'b1;
                    miso_s_d = bus.MISO;
                end
            end
            ST_SHIFT: begin
                if (tick && !last_bit_done) begin
                    if (sclk_q) begin
                        // Sampled bit enters on the shift so tx bits are never overwritten.
                        sclk_d    = 1'b0;
                        shreg_d   = {shreg_q[DATA_W-2:0], miso_s_q};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q != BCW'(DATA_W - 1)) mosi_d = shreg_q[DATA_W-2];
                    end else begin
                        sclk_d   = 1'b1;
                        miso_s_d = bus.MISO;
                    end
                end
            end
            ST_TRAIL: begin
                if (tick) begin
                    ss_n_d = 1'b1;
                    mosi_d = 1'b0;
                    rx_d   = shreg_q;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            shreg_q   <= '0;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            miso_s_q  <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ss_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            rx_q      <= rx_d;
            bit_cnt_q <= bit_cnt_d;
            miso_s_q  <= miso_s_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ss_n_q    <= ss_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.rx_data   = rx_q;
    assign bus.spi_done  = done_q;
    assign bus.SCLK      = sclk_q;
    assign bus.MOSI      = mosi_q;
    assign bus.SS_n      = ss_n_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_spi_master_engine.sv
// Bench for spi_master_engine: default 16-bit/div-4 instance and an 8-bit/div-1 instance.
module tb_spi_master_engine;
    import spi_pkg::*;

    logic PCLK = 1'b0;
    logic PRESET;
    always #5 PCLK = ~PCLK;

    spi_master_engine_if #(.DATA_W(16)) if0 ();
    spi_master_engine_if #(.DATA_W(8))  if1 ();

    spi_master_engine #(.DATA_W(16), .CLK_DIV(4)) u_dut0 (.PCLK(PCLK), .PRESET(PRESET), .bus(if0));
    spi_master_engine #(.DATA_W(8),  .CLK_DIV(1)) u_dut1 (.PCLK(PCLK), .PRESET(PRESET), .bus(if1));

    // Slave for instance 0: loopback or a mode-0 slave shifting out slave_word.
    logic        loop0;
    logic [15:0] slave_word;
    int          slave_idx;
    always @(negedge if0.SS_n) slave_idx = 0;
    always @(negedge if0.SCLK) if (!if0.SS_n) slave_idx = slave_idx + 1;
    assign if0.MISO = loop0 ? if0.MOSI : ((slave_idx < 16) ? slave_word[15 - slave_idx] : 1'b0);
    assign if1.MISO = if1.MOSI;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Flattened views of both instances.
    logic        st_v[2];
    logic [15:0] tx_v[2];
    logic [15:0] rx_v[2];
    logic        busy_v[2], done_v[2], sclk_v[2], mosi_v[2], ssn_v[2];
    assign st_v[0] = if0.start;  assign st_v[1] = if1.start;
    assign tx_v[0] = if0.tx_data; assign tx_v[1] = {8'h00, if1.tx_data};
    assign rx_v[0] = if0.rx_data; assign rx_v[1] = {8'h00, if1.rx_data};
    assign busy_v[0] = if0.busy;  assign busy_v[1] = if1.busy;
    assign done_v[0] = if0.spi_done; assign done_v[1] = if1.spi_done;
    assign sclk_v[0] = if0.SCLK;  assign sclk_v[1] = if1.SCLK;
    assign mosi_v[0] = if0.MOSI;  assign mosi_v[1] = if1.MOSI;
    assign ssn_v[0]  = if0.SS_n;  assign ssn_v[1]  = if1.SS_n;

    function automatic int wof(input int i); return (i == 0) ? 16 : 8; endfunction
    function automatic int dof(input int i); return (i == 0) ? 4 : 1; endfunction

    // Transaction-level model: cycles elapsed since accept decide every output.
    logic        m_busy[2], m_done[2];
    logic [15:0] m_rx[2], m_tx[2], m_exp[2];
    int          m_cnt[2];
    logic        chk_en = 1'b0;

    always @(posedge PCLK) begin
        for (int i = 0; i < 2; i++) begin
            if (PRESET) begin
                m_busy[i] = 1'b0; m_done[i] = 1'b0; m_rx[i] = '0; m_cnt[i] = 0; m_tx[i] = '0;
            end else if (!m_busy[i]) begin
                if (st_v[i]) begin
                    m_busy[i] = 1'b1; m_done[i] = 1'b0; m_cnt[i] = 0; m_tx[i] = tx_v[i];
                    m_exp[i]  = (i == 0 && !loop0) ? slave_word : tx_v[i];
                end
            end else begin
                m_cnt[i]++;
                if (m_cnt[i] == (2 * wof(i) + 2) * dof(i)) begin
                    m_busy[i] = 1'b0; m_done[i] = 1'b1; m_rx[i] = m_exp[i];
                end
            end
        end
        chk_en = 1'b1;
    end

    always @(negedge PCLK) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int  w, d, ph, j;
                logic e_sclk, e_mosi;
                w  = wof(i);
                d  = dof(i);
                ph = m_cnt[i] / d;
                j  = m_cnt[i] / (2 * d);
                if (j > w - 1) j = w - 1;
                e_sclk = m_busy[i] && (ph % 2 == 1) && (ph < 2 * w);
                e_mosi = m_busy[i] ? m_tx[i][w - 1 - j] : 1'b0;
                chk($sformatf("u%0d_busy", i), 16'(busy_v[i]), 16'(m_busy[i]));
                chk($sformatf("u%0d_done", i), 16'(done_v[i]), 16'(m_done[i]));
                chk($sformatf("u%0d_rx", i),   rx_v[i], m_rx[i]);
                chk($sformatf("u%0d_ss_n", i), 16'(ssn_v[i]), 16'(!m_busy[i]));
                chk($sformatf("u%0d_sclk", i), 16'(sclk_v[i]), 16'(e_sclk));
                chk($sformatf("u%0d_mosi", i), 16'(mosi_v[i]), 16'(e_mosi));
            end
        end
    end

    int          rise0;
    logic [15:0] mseq0;
    always @(posedge if0.SCLK) begin
        rise0 = rise0 + 1;
        mseq0 = {mseq0[14:0], if0.MOSI};
    end

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // Runs one instance-0 transfer; poke_at injects start, rst_at injects PRESET.
    task automatic xfer0(input logic [15:0] tx, input logic [15:0] prev_rx,
                         input int poke_at, input int rst_at, output int lat);
        int  cnt;
        logic did_rst;
        rise0 = 0;
        mseq0 = '0;
        if0.tx_data = tx;
        if0.start   = 1'b1;
        tick(1);
        if0.start   = 1'b0;
        if0.tx_data = ~tx;
        chk("accept_done_clr", 16'(if0.spi_done), 16'd0);
        chk("accept_busy", 16'(if0.busy), 16'd1);
        chk("accept_rx_hold", if0.rx_data, prev_rx);
        cnt = 0;
        lat = -1;
        did_rst = 1'b0;
        while (!if0.spi_done && cnt < 400) begin
            if (cnt == poke_at) if0.start = 1'b1;
            if (cnt == rst_at) begin PRESET = 1'b1; did_rst = 1'b1; end
            tick(1);
            cnt++;
            if0.start = 1'b0;
            if (did_rst) begin
                PRESET = 1'b0;
                chk("rst_ss_n", 16'(if0.SS_n), 16'd1);
                chk("rst_sclk", 16'(if0.SCLK), 16'd0);
                chk("rst_busy", 16'(if0.busy), 16'd0);
                chk("rst_done", 16'(if0.spi_done), 16'd0);
                chk("rst_rx",   if0.rx_data, 16'h0000);
                return;
            end
        end
        if (if0.spi_done) lat = cnt;
    endtask

    initial begin
        int lat;
        PRESET = 1'b1;
        if0.start = 1'b0; if0.tx_data = '0;
        if1.start = 1'b0; if1.tx_data = '0;
        loop0 = 1'b1; slave_word = '0; slave_idx = 0;
        rise0 = 0; mseq0 = '0;
        tick(2);
        chk("reset_ss_n", 16'(if0.SS_n), 16'd1);
        chk("reset_sclk", 16'(if0.SCLK), 16'd0);
        chk("reset_mosi", 16'(if0.MOSI), 16'd0);
        chk("reset_busy", 16'(if0.busy), 16'd0);
        chk("reset_done", 16'(if0.spi_done), 16'd0);
        chk("reset_rx",   if0.rx_data, 16'h0000);
        chk("reset_state0", 16'(if0.state_dbg), 16'(ST_IDLE));
        chk("reset_state1", 16'(if1.state_dbg), 16'(ST_IDLE));
        PRESET = 1'b0;
        tick(3);

        // Loopback of A5C3.
        xfer0(16'hA5C3, 16'h0000, -1, -1, lat);
        chk("loop_latency", 16'(lat), 16'd136);
        chk("loop_rx", if0.rx_data, 16'hA5C3);
        chk("loop_ss_n", 16'(if0.SS_n), 16'd1);
        chk("loop_rises", 16'(rise0), 16'd16);
        chk("loop_mosi_seq", mseq0, 16'b1010010111000011);

        // Slave returns 3C96 while transmitting zeros.
        loop0 = 1'b0; slave_word = 16'h3C96;
        xfer0(16'h0000, 16'hA5C3, -1, -1, lat);
        chk("slave_latency", 16'(lat), 16'd136);
        chk("slave_rx", if0.rx_data, 16'h3C96);
        tick(50);
        chk("slave_done_sticky", 16'(if0.spi_done), 16'd1);
        chk("slave_rx_sticky", if0.rx_data, 16'h3C96);

        // Start while busy is ignored.
        loop0 = 1'b1;
        xfer0(16'h1234, 16'h3C96, 40, -1, lat);
        chk("busy_start_latency", 16'(lat), 16'd136);
        chk("busy_start_rises", 16'(rise0), 16'd16);
        chk("busy_start_rx", if0.rx_data, 16'h1234);

        // Reset mid-transfer, then a normal transfer.
        xfer0(16'hBEEF, 16'h1234, -1, 60, lat);
        tick(2);
        xfer0(16'h5A0F, 16'h0000, -1, -1, lat);
        chk("post_rst_latency", 16'(lat), 16'd136);
        chk("post_rst_rx", if0.rx_data, 16'h5A0F);

        // Start coinciding with the completing TRAIL edge is ignored.
        xfer0(16'h0F0F, 16'h5A0F, 135, -1, lat);
        chk("trail_start_latency", 16'(lat), 16'd136);
        tick(2);
        chk("trail_start_ignored", 16'(if0.busy), 16'd0);
        chk("trail_start_rx", if0.rx_data, 16'h0F0F);

        // CLK_DIV=1, DATA_W=8 loopback.
        if1.tx_data = 8'h81;
        if1.start   = 1'b1;
        tick(1);
        if1.start   = 1'b0;
        if1.tx_data = 8'h00;
        lat = 0;
        while (!if1.spi_done && lat < 100) begin
            tick(1);
            lat++;
        end
        chk("div1_latency", 16'(lat), 16'd18);
        chk("div1_rx", 16'(if1.rx_data), 16'h0081);
        tick(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
